// File: rtl/fifo_rd_pkg.sv
// Shared state encoding and buffer sizing
// for the FIFO burst reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 3;

endpackage

// File: rtl/fifo_burst_reader_buf.sv
// Three-entry register FIFO that absorbs FIFO read latency
// and sink back-pressure in front of the tx port.
module fifo_burst_reader_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;

    function automatic logic [1:0] inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Push into a full buffer is legal only alongside a pop of the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
        end else begin
            assert (!(push && !pop && occ == 2'(BUF_DEPTH)));
            assert (!(pop && occ == 2'd0));
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of N words from the DPRAM FIFO and streams them
// to a valid/ready sink, flagging the final word.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       i_Rst_L,
    input  logic                       i_Clk,
    input  logic                       i_Start,
    input  logic [$clog2(MAX_BURST):0] i_Burst_Len,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_Rd_En,
    input  logic                       i_Empty,
    input  logic                       i_Rd_DV,
    input  logic [WIDTH-1:0]           i_Rd_Data,
    output logic                       o_Tx_DV,
    output logic [WIDTH-1:0]           o_Tx_Data,
    output logic                       o_Tx_Last,
    input  logic                       i_Tx_Ready
);

    localparam int            LW      = $clog2(MAX_BURST) + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BURST);
    localparam logic [LW-1:0] CREDITS = LW'(BUF_DEPTH - 1);

    state_t        state;
    state_t        state_nx;
    logic [LW-1:0] len;
    logic [LW-1:0] len_in;
    logic [LW-1:0] req;
    logic [LW-1:0] sent;
    logic [LW-1:0] inflt;
    logic [LW-1:0] credit;
    logic [1:0]    occ;
    logic          start_ok;
    logic          push;
    logic          pop;

    assign len_in   = (i_Burst_Len > MAX_LEN) ? MAX_LEN : i_Burst_Len;
    assign start_ok = (state == IDLE) & i_Start;

    // Credit counts both buffered words and words still in the FIFO pipe,
    // so o_Rd_En depends only on registered state, never on i_Tx_Ready.
    assign credit  = LW'(occ) + inflt;
    assign o_Rd_En = (state == READ) & (req < len) & ~i_Empty
                   & (credit <= CREDITS);

    // A DV with no outstanding request is stale and must not be buffered.
    assign push = i_Rd_DV & (inflt != '0);
    assign pop  = o_Tx_DV & i_Tx_Ready;

    assign o_Tx_DV   = (occ != 2'd0);
    assign o_Tx_Last = o_Tx_DV & (sent == len - LW'(1));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        o_Busy   = 1'b0;
        o_Done   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_Start) begin
                    state_nx = (len_in == '0) ? DONE : READ;
                end
            end
            READ: begin
                o_Busy = 1'b1;
                if (req == len) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                o_Busy = 1'b1;
                if (pop && o_Tx_Last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                o_Done   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            len   <= '0;
            req   <= '0;
            sent  <= '0;
            inflt <= '0;
        end else begin
            if (start_ok) begin
                len  <= len_in;
                req  <= '0;
                sent <= '0;
            end else begin
                if (o_Rd_En) begin
                    req <= req + LW'(1);
                end
                if (pop) begin
                    sent <= sent + LW'(1);
                end
            end
            inflt <= inflt + LW'(o_Rd_En) - LW'(push);
        end
    end

    fifo_burst_reader_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .push  (push),
        .pop   (pop),
        .din   (i_Rd_Data),
        .dout  (o_Tx_Data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a transaction-level
// model of the burst and a 1-cycle-latency FIFO stand-in.
module tb_fifo_burst_reader;

    logic       i_Rst_L;
    logic       i_Clk;
    logic       i_Start;
    logic [4:0] i_Burst_Len;
    logic       o_Busy;
    logic       o_Done;
    logic       o_Rd_En;
    logic       i_Empty;
    logic       i_Rd_DV;
    logic [7:0] i_Rd_Data;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Data;
    logic       o_Tx_Last;
    logic       i_Tx_Ready;

    fifo_burst_reader #(
        .WIDTH     (8),
        .MAX_BURST (16)
    ) dut (
        .i_Rst_L     (i_Rst_L),
        .i_Clk       (i_Clk),
        .i_Start     (i_Start),
        .i_Burst_Len (i_Burst_Len),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Rd_En     (o_Rd_En),
        .i_Empty     (i_Empty),
        .i_Rd_DV     (i_Rd_DV),
        .i_Rd_Data   (i_Rd_Data),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Data   (o_Tx_Data),
        .o_Tx_Last   (o_Tx_Last),
        .i_Tx_Ready  (i_Tx_Ready)
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    bit         inject = 0;

    // model state
    bit m_active = 0;
    bit m_done   = 0;
    int m_len    = 0;
    int m_sent   = 0;
    int m_req    = 0;

    // per-test statistics
    int rd_cnt, first_rd, last_rd;
    int tx_cnt, first_tx, last_tx;
    int done_cnt, done_cyc, start_cyc;
    logic [7:0] first_data, last_data;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    initial begin
        i_Clk = 0;
        forever #5 i_Clk = ~i_Clk;
    end

    always @(posedge i_Clk) cyc <= cyc + 1;

    // FIFO stand-in: data and DV appear one cycle after a pop request.
    initial begin
        bit pop_s;
        i_Rd_DV   = 0;
        i_Rd_Data = 0;
        i_Empty   = 1;
        forever begin
            @(negedge i_Clk);
            pop_s = o_Rd_En;
            @(posedge i_Clk);
            #1;
            if (pop_s && fq.size() > 0) begin
                i_Rd_DV   = 1;
                i_Rd_Data = fq.pop_front();
            end else if (inject) begin
                i_Rd_DV   = 1;
                i_Rd_Data = 8'hEE;
                inject    = 0;
            end else begin
                i_Rd_DV   = 0;
            end
            i_Empty = (fq.size() == 0);
        end
    end

    // Compare process: checks every cycle against the burst model.
    initial begin
        bit         xfer, idle, nd, p_stall;
        logic [7:0] p_data, ed;
        bit         p_last, exp_last;
        int         L;
        p_stall = 0;
        p_data  = 0;
        p_last  = 0;
        forever begin
            @(negedge i_Clk);
            if (!i_Rst_L) begin
                chk({o_Busy, o_Done, o_Rd_En, o_Tx_DV, o_Tx_Last, o_Tx_Data} == '0,
                    "reset_outputs",
                    {o_Busy, o_Done, o_Rd_En, o_Tx_DV, o_Tx_Last, o_Tx_Data}, 0);
                m_active = 0;
                m_done   = 0;
                m_sent   = 0;
                m_req    = 0;
                m_len    = 0;
                p_stall  = 0;
            end else begin
                xfer = o_Tx_DV & i_Tx_Ready;
                chk(o_Done == m_done, "done", o_Done, m_done);
                chk(o_Busy == m_active, "busy", o_Busy, m_active);
                if (o_Done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (o_Rd_En) begin
                    chk(!i_Empty && m_active && m_req < m_len, "rd_en_legal",
                        {i_Empty, m_active}, 32'h1);
                    if (rd_cnt == 0) first_rd = cyc;
                    last_rd = cyc;
                    rd_cnt++;
                    m_req++;
                end
                if (o_Tx_DV) begin
                    exp_last = m_active && (m_sent == m_len - 1);
                    chk(m_active && o_Tx_Last == exp_last, "tx_last",
                        {m_active, o_Tx_Last}, {1'b1, exp_last});
                end
                if (p_stall) begin
                    chk(o_Tx_DV && o_Tx_Data == p_data && o_Tx_Last == p_last,
                        "stall_hold", {o_Tx_DV, o_Tx_Last, o_Tx_Data},
                        {1'b1, p_last, p_data});
                end
                if (xfer) begin
                    ed = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    chk(o_Tx_Data === ed, "tx_data", o_Tx_Data, ed);
                    if (tx_cnt == 0) begin
                        first_tx   = cyc;
                        first_data = o_Tx_Data;
                    end
                    last_tx   = cyc;
                    last_data = o_Tx_Data;
                    tx_cnt++;
                end
                idle = !m_active && !m_done;
                nd   = 0;
                if (xfer && m_active) begin
                    if (m_sent == m_len - 1) begin
                        m_active = 0;
                        nd       = 1;
                    end
                    m_sent++;
                end
                if (idle && i_Start) begin
                    L         = (i_Burst_Len > 16) ? 16 : int'(i_Burst_Len);
                    start_cyc = cyc;
                    if (L == 0) begin
                        nd = 1;
                    end else begin
                        m_active = 1;
                        m_len    = L;
                        m_sent   = 0;
                        m_req    = 0;
                    end
                end
                m_done  = nd;
                p_stall = o_Tx_DV & ~i_Tx_Ready;
                p_data  = o_Tx_Data;
                p_last  = o_Tx_Last;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_stats();
        rd_cnt   = 0; first_rd = -1; last_rd = -1;
        tx_cnt   = 0; first_tx = -1; last_tx = -1;
        done_cnt = 0; done_cyc = -1; start_cyc = -1;
        first_data = 0; last_data = 0;
    endtask

    task automatic put(input logic [7:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic start(input logic [4:0] len);
        @(posedge i_Clk); #1;
        i_Start     = 1;
        i_Burst_Len = len;
        @(posedge i_Clk); #1;
        i_Start     = 0;
    endtask

    task automatic run_done(input int max, input bit toggle, input string name);
        int n = 0;
        while (!o_Done && n < max) begin
            @(posedge i_Clk); #1;
            if (toggle) i_Tx_Ready = ~i_Tx_Ready;
            n++;
        end
        chk(o_Done, name, n, max);
        @(posedge i_Clk); #1;
        i_Tx_Ready = 1;
    endtask

    task automatic flush();
        repeat (3) @(posedge i_Clk);
        #1;
        fq.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        i_Rst_L     = 0;
        i_Start     = 0;
        i_Burst_Len = 0;
        i_Tx_Ready  = 1;
        clear_stats();
        repeat (3) @(posedge i_Clk);
        #1;
        i_Rst_L = 1;

        // 1: Len=4, back-to-back
        clear_stats();
        for (int i = 0; i < 4; i++) put(8'h11 + 8'(i));
        start(4);
        run_done(40, 0, "t1_timeout");
        chk(first_rd == start_cyc + 1, "t1_first_rd", first_rd, start_cyc + 1);
        chk(rd_cnt == 4 && last_rd == first_rd + 3, "t1_rd_run", rd_cnt, 4);
        chk(first_tx == start_cyc + 3, "t1_first_tx", first_tx, start_cyc + 3);
        chk(tx_cnt == 4 && last_tx == first_tx + 3, "t1_tx_run", tx_cnt, 4);
        chk(first_data == 8'h11, "t1_first_data", first_data, 8'h11);
        chk(last_data == 8'h14, "t1_last_data", last_data, 8'h14);
        chk(done_cyc == last_tx + 1, "t1_done_cyc", done_cyc, last_tx + 1);
        chk(done_cnt == 1, "t1_done_cnt", done_cnt, 1);
        flush();

        // 2: Len=8, ready toggling
        clear_stats();
        for (int i = 0; i < 8; i++) put(8'h21 + 8'(i));
        start(8);
        run_done(80, 1, "t2_timeout");
        chk(tx_cnt == 8, "t2_tx_cnt", tx_cnt, 8);
        chk(last_data == 8'h28, "t2_last_data", last_data, 8'h28);
        chk(done_cnt == 1, "t2_done_cnt", done_cnt, 1);
        flush();

        // 3: FIFO runs dry mid-burst
        clear_stats();
        put(8'h31);
        put(8'h32);
        start(6);
        repeat (10) @(posedge i_Clk);
        #1;
        chk(rd_cnt == 2, "t3_rd_stalled", rd_cnt, 2);
        for (int i = 0; i < 4; i++) put(8'h33 + 8'(i));
        run_done(60, 0, "t3_timeout");
        chk(tx_cnt == 6 && rd_cnt == 6, "t3_count", tx_cnt, 6);
        chk(last_data == 8'h36, "t3_last_data", last_data, 8'h36);
        flush();

        // 4a: Len=0
        clear_stats();
        start(0);
        run_done(10, 0, "t4a_timeout");
        chk(done_cyc == start_cyc + 1, "t4a_done_cyc", done_cyc, start_cyc + 1);
        chk(rd_cnt == 0 && tx_cnt == 0, "t4a_no_traffic", rd_cnt + tx_cnt, 0);
        flush();

        // 4b: Len=31 clamps to 16
        clear_stats();
        for (int i = 0; i < 20; i++) put(8'h40 + 8'(i));
        start(31);
        run_done(100, 0, "t4b_timeout");
        chk(tx_cnt == 16, "t4b_tx_cnt", tx_cnt, 16);
        chk(exp_q.size() == 4, "t4b_left", exp_q.size(), 4);
        chk(last_data == 8'h4F, "t4b_last_data", last_data, 8'h4F);
        flush();

        // 5: reset mid-burst, then a fresh Len=2 burst
        clear_stats();
        for (int i = 0; i < 8; i++) put(8'h51 + 8'(i));
        start(8);
        n = 0;
        while (tx_cnt < 2 && n < 40) begin
            @(posedge i_Clk); #1;
            n++;
        end
        chk(tx_cnt >= 2, "t5_wait_two", tx_cnt, 2);
        i_Rst_L = 0;
        repeat (3) @(posedge i_Clk);
        #1;
        fq.delete();
        exp_q.delete();
        i_Rst_L = 1;
        inject  = 1;
        repeat (4) @(posedge i_Clk);
        #1;
        clear_stats();
        put(8'hA1);
        put(8'hA2);
        start(2);
        run_done(40, 0, "t5_timeout");
        chk(tx_cnt == 2, "t5_tx_cnt", tx_cnt, 2);
        chk(first_data == 8'hA1 && last_data == 8'hA2, "t5_data",
            {first_data, last_data}, 16'hA1A2);
        chk(done_cnt == 1, "t5_done_cnt", done_cnt, 1);
        flush();

        // 6: start pulsed during READ is ignored
        clear_stats();
        for (int i = 0; i < 8; i++) put(8'h61 + 8'(i));
        start(5);
        @(posedge i_Clk); #1;
        i_Start     = 1;
        i_Burst_Len = 2;
        @(posedge i_Clk); #1;
        i_Start     = 0;
        run_done(60, 0, "t6_timeout");
        repeat (5) @(posedge i_Clk);
        #1;
        chk(done_cnt == 1, "t6_done_cnt", done_cnt, 1);
        chk(tx_cnt == 5, "t6_tx_cnt", tx_cnt, 5);
        chk(exp_q.size() == 3, "t6_left", exp_q.size(), 3);
        flush();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
